// File: rtl/matrix_spi_rx.sv
// Matrix-tile receiver: oversamples the SPI pixel stream and the column-select shift chain,
// and turns 24-bit words into addressed pixel writes. Optional counters: MATRIX_RX_STATS_EN.
module matrix_spi_rx #(
   parameter int SPI_SIZE         = 24,
   parameter int MSB_FIRST        = 1,
   parameter int WORDS_PER_MATRIX = 128,
   parameter int CHAIN_LENGTH     = 16,
   parameter int TAP_INDEX        = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                spi_clk,
   input  logic                                spi_mosi,
   input  logic                                ser_clk,
   input  logic                                ser_data,
   input  logic                                ser_stcp,
   input  logic                                ser_n_enable,
   output logic [SPI_SIZE-1:0]                 pix_data,
   output logic [$clog2(WORDS_PER_MATRIX)-1:0] pix_addr,
   output logic                                pix_valid,
   output logic                                frame_done,
   output logic                                selected,
   output logic                                err_overrun,
   output logic                                err_partial,
   output logic [15:0]                         frame_count,
   output logic [15:0]                         error_count
);
   localparam int AW = $clog2(WORDS_PER_MATRIX);
   localparam int BW = $clog2(SPI_SIZE + 1);
   localparam logic [AW-1:0] LAST_WORD = AW'(WORDS_PER_MATRIX - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(SPI_SIZE - 1);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t                  state;
   logic [5:0]              meta, sync;
   logic [2:0]              prev;
   logic [CHAIN_LENGTH-1:0] chain, latch, latch_nxt;
   logic [SPI_SIZE-1:0]     shreg, word_nxt;
   logic [BW-1:0]           bit_cnt;
   logic [AW-1:0]           word_cnt;

   logic s_spi_clk, s_mosi, s_ser_clk, s_ser_data, s_stcp, s_n_en;
   logic spi_rise, ser_rise, stcp_rise;
   logic sel_nxt, sel_rise, sel_fall, new_frame;
   logic take_bit, word_end, last_word, ovr_evt, part_evt;

   assign {s_spi_clk, s_mosi, s_ser_clk, s_ser_data, s_stcp, s_n_en} = sync;
   assign spi_rise  = s_spi_clk & ~prev[2];
   assign ser_rise  = s_ser_clk & ~prev[1];
   assign stcp_rise = s_stcp    & ~prev[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= {spi_clk, spi_mosi, ser_clk, ser_data, ser_stcp, ser_n_enable};
         sync <= meta;
         prev <= {s_spi_clk, s_ser_clk, s_stcp};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         latch <= '0;
      end else begin
         if (ser_rise)  chain <= {chain[CHAIN_LENGTH-2:0], s_ser_data};
         if (stcp_rise) latch <= chain;
      end
   end

   // Selection is evaluated against the latch value of this cycle's strobe so a
   // new-frame strobe and the selection it implies are seen together.
   assign latch_nxt = stcp_rise ? chain : latch;
   assign sel_nxt   = latch_nxt[TAP_INDEX] & ~s_n_en;
   assign sel_rise  = sel_nxt & ~selected;
   assign sel_fall  = selected & ~sel_nxt;
   assign new_frame = stcp_rise & chain[0];

   assign word_nxt  = (MSB_FIRST != 0) ? {shreg[SPI_SIZE-2:0], s_mosi}
                                       : {s_mosi, shreg[SPI_SIZE-1:1]};
   assign take_bit  = (state == RECV) & spi_rise & ~new_frame & ~sel_fall;
   assign word_end  = take_bit & (bit_cnt == LAST_BIT);
   assign last_word = word_end & (word_cnt == LAST_WORD);
   assign ovr_evt   = (state == DONE) & spi_rise & ~new_frame & ~sel_fall;
   assign part_evt  = (state != IDLE) & sel_fall & ~new_frame & (bit_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         pix_data    <= '0;
         pix_addr    <= '0;
         pix_valid   <= 1'b0;
         frame_done  <= 1'b0;
         selected    <= 1'b0;
         err_overrun <= 1'b0;
         err_partial <= 1'b0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         selected   <= sel_nxt;
         if (ovr_evt)  err_overrun <= 1'b1;
         if (part_evt) err_partial <= 1'b1;
         if (new_frame) begin
            word_cnt <= '0;
            bit_cnt  <= '0;
            state    <= sel_nxt ? RECV : IDLE;
         end else if (sel_fall && state != IDLE) begin
            // word_cnt survives so a column can be split over several selections
            bit_cnt <= '0;
            state   <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (sel_rise) begin
                     bit_cnt <= '0;
                     state   <= RECV;
                  end
               end
               RECV: begin
                  if (take_bit) begin
                     shreg <= word_nxt;
                     if (word_end) begin
                        pix_valid <= 1'b1;
                        pix_data  <= word_nxt;
                        pix_addr  <= word_cnt;
                        bit_cnt   <= '0;
                        if (last_word) begin
                           frame_done <= 1'b1;
                           state      <= DONE;
                        end else begin
                           word_cnt <= word_cnt + AW'(1);
                        end
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end
               end
               DONE:    ;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef MATRIX_RX_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count <= '0;
         error_count <= '0;
      end else begin
         if (last_word)          frame_count <= sat_inc(frame_count);
         if (ovr_evt | part_evt) error_count <= sat_inc(error_count);
      end
   end
`else
   assign frame_count = '0;
   assign error_count = '0;
`endif

endmodule

// File: tb/tb_matrix_spi_rx.sv
// Scoreboard bench for matrix_spi_rx: dut 0 uses default parameters, dut 1 is LSB-first on tap 3.
module tb_matrix_spi_rx;
`ifdef MATRIX_RX_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   typedef struct {
      logic [23:0] data;
      logic [6:0]  addr;
      logic        fd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk[2], mosi[2], serclk[2], sdata[2], stcp[2], nen[2];
   logic [23:0] pdata[2];
   logic [6:0]  paddr[2];
   logic        pvalid[2], fdone[2], sel[2], eovr[2], epart[2];
   logic [15:0] fcnt[2], ecnt[2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   matrix_spi_rx u_dut (
      .clk(clk), .rst_n(rst_n),
      .spi_clk(sclk[0]), .spi_mosi(mosi[0]), .ser_clk(serclk[0]), .ser_data(sdata[0]),
      .ser_stcp(stcp[0]), .ser_n_enable(nen[0]),
      .pix_data(pdata[0]), .pix_addr(paddr[0]), .pix_valid(pvalid[0]), .frame_done(fdone[0]),
      .selected(sel[0]), .err_overrun(eovr[0]), .err_partial(epart[0]),
      .frame_count(fcnt[0]), .error_count(ecnt[0])
   );

   matrix_spi_rx #(.MSB_FIRST(0), .TAP_INDEX(3)) u_alt (
      .clk(clk), .rst_n(rst_n),
      .spi_clk(sclk[1]), .spi_mosi(mosi[1]), .ser_clk(serclk[1]), .ser_data(sdata[1]),
      .ser_stcp(stcp[1]), .ser_n_enable(nen[1]),
      .pix_data(pdata[1]), .pix_addr(paddr[1]), .pix_valid(pvalid[1]), .frame_done(fdone[1]),
      .selected(sel[1]), .err_overrun(eovr[1]), .err_partial(epart[1]),
      .frame_count(fcnt[1]), .error_count(ecnt[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int d, input logic [23:0] data, input int addr, input logic fd);
      exp_t e;
      e.data = data;
      e.addr = 7'(addr);
      e.fd   = fd;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic spi_bit(input int d, input logic b);
      mosi[d] = b;
      tick(2);
      sclk[d] = 1'b1;
      tick(4);
      sclk[d] = 1'b0;
      tick(2);
   endtask

   task automatic send_word(input int d, input logic [23:0] w, input bit msb);
      for (int i = 0; i < 24; i++) spi_bit(d, msb ? w[23-i] : w[i]);
   endtask

   task automatic ser_shift(input int d, input logic b);
      sdata[d] = b;
      tick(2);
      serclk[d] = 1'b1;
      tick(4);
      serclk[d] = 1'b0;
      tick(2);
   endtask

   task automatic strobe(input int d);
      stcp[d] = 1'b1;
      tick(4);
      stcp[d] = 1'b0;
      tick(2);
   endtask

   task automatic load_bit0(input int d);
      for (int i = 0; i < 15; i++) ser_shift(d, 1'b0);
      ser_shift(d, 1'b1);
      strobe(d);
   endtask

   task automatic check_reset(input int d);
      check($sformatf("rst_pix_data%0d", d), 32'(pdata[d]), 0);
      check($sformatf("rst_pix_addr%0d", d), 32'(paddr[d]), 0);
      check($sformatf("rst_pix_valid%0d", d), 32'(pvalid[d]), 0);
      check($sformatf("rst_frame_done%0d", d), 32'(fdone[d]), 0);
      check($sformatf("rst_selected%0d", d), 32'(sel[d]), 0);
      check($sformatf("rst_err_overrun%0d", d), 32'(eovr[d]), 0);
      check($sformatf("rst_err_partial%0d", d), 32'(epart[d]), 0);
      check($sformatf("rst_frame_count%0d", d), 32'(fcnt[d]), 0);
      check($sformatf("rst_error_count%0d", d), 32'(ecnt[d]), 0);
   endtask

   task automatic monitor(input int d);
      exp_t e;
      if (pvalid[d]) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pix%0d: got addr %0d data %0h expected no write", d, paddr[d], pdata[d]);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("pix_data%0d@%0d", d, e.addr), 32'(pdata[d]), 32'(e.data));
            check($sformatf("pix_addr%0d@%0d", d, e.addr), 32'(paddr[d]), 32'(e.addr));
            check($sformatf("frame_done%0d@%0d", d, e.addr), 32'(fdone[d]), 32'(e.fd));
         end
      end else if (fdone[d]) begin
         n_vec++;
         n_err++;
         $display("FAIL stray_frame_done%0d: got 1 expected 0", d);
      end
   endtask

   always @(negedge clk) if (rst_n) monitor(0);
   always @(negedge clk) if (rst_n) monitor(1);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         sclk[d] = 0; mosi[d] = 0; serclk[d] = 0; sdata[d] = 0; stcp[d] = 0; nen[d] = 1;
      end
      tick(4);
      check_reset(0);
      check_reset(1);
      rst_n = 1'b1;
      tick(2);

      // full frame on tile 0
      load_bit0(0);
      nen[0] = 1'b0;
      tick(6);
      check("select0", 32'(sel[0]), 1);
      for (int w = 0; w < 128; w++) begin
         push(0, 24'(w), w, w == 127);
         send_word(0, 24'(w), 1'b1);
      end
      tick(4);
      check("frame_count", 32'(fcnt[0]), STATS);
      check("no_overrun_yet", 32'(eovr[0]), 0);

      // overrun after frame completion
      for (int i = 0; i < 5; i++) spi_bit(0, 1'b1);
      tick(4);
      check("err_overrun", 32'(eovr[0]), 1);
      check("error_count_ovr", 32'(ecnt[0]), STATS * 5);

      // new frame, one word, then a partial word cut by deselect
      strobe(0);
      tick(2);
      push(0, 24'h111111, 0, 1'b0);
      send_word(0, 24'h111111, 1'b1);
      for (int i = 0; i < 10; i++) spi_bit(0, i[0]);
      nen[0] = 1'b1;
      tick(6);
      check("err_partial", 32'(epart[0]), 1);
      check("deselect", 32'(sel[0]), 0);
      check("overrun_sticky", 32'(eovr[0]), 1);
      check("error_count_part", 32'(ecnt[0]), STATS * 6);
      nen[0] = 1'b0;
      tick(6);
      check("reselect", 32'(sel[0]), 1);
      push(0, 24'h123456, 1, 1'b0);
      send_word(0, 24'h123456, 1'b1);

      // tile 1: select bit at chain position 0 does not reach tap 3
      load_bit0(1);
      nen[1] = 1'b0;
      tick(6);
      check("alt_unselected", 32'(sel[1]), 0);
      send_word(1, 24'hFFFFFF, 1'b0);
      tick(4);
      for (int i = 0; i < 3; i++) ser_shift(1, 1'b0);
      strobe(1);
      tick(2);
      check("alt_selected", 32'(sel[1]), 1);
      push(1, 24'hA5C3F0, 0, 1'b0);
      send_word(1, 24'hA5C3F0, 1'b0);
      tick(4);

      // continue tile 0 up to word 40, then restart the frame
      for (int w = 2; w < 40; w++) begin
         push(0, 24'(w * 24'h010101), w, 1'b0);
         send_word(0, 24'(w * 24'h010101), 1'b1);
      end
      strobe(0);
      tick(2);
      push(0, 24'hABCDEF, 0, 1'b0);
      send_word(0, 24'hABCDEF, 1'b1);

      // reset mid-word
      for (int i = 0; i < 12; i++) spi_bit(0, 1'b1);
      rst_n = 1'b0;
      tick(3);
      check_reset(0);
      check_reset(1);
      rst_n = 1'b1;
      tick(6);
      check("post_reset_selected", 32'(sel[0]), 0);
      check("q0_drained", 32'(q0.size()), 0);
      check("q1_drained", 32'(q1.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/matrix_spi_rx.md
Name: matrix_spi_rx

Overview:
Matrix-side receiver for the SPI and shift-register column-select stream driven onto the LED matrix tiles. It oversamples spi_clk/spi_mosi and the column shift-register signals (ser_clk, ser_data, ser_stcp, ser_n_enable) in the system clock domain. It tracks whether its own tile is selected and reassembles 24-bit pixel words into addressed pixel writes with a frame-complete strobe. It serves as the FPGA tile implementation and as the loopback checker for the transmit path.

Parameters:
SPI_SIZE, 24, bits per SPI word (one RGB pixel)
MSB_FIRST, 1, 1 = first received bit lands in bit SPI_SIZE-1
WORDS_PER_MATRIX, 128, pixel words per tile per frame (16x8)
CHAIN_LENGTH, 16, column shift-register chain length
TAP_INDEX, 0, chain position that selects this tile (0..CHAIN_LENGTH-1)

Ports:
clk  in  1  system clock, must be at least 4x the spi_clk and ser_clk rates
rst_n  in  1  asynchronous active-low reset
spi_clk  in  1  SPI clock, asynchronous
spi_mosi  in  1  SPI data, asynchronous
ser_clk  in  1  column shift clock, asynchronous
ser_data  in  1  column shift serial data, asynchronous
ser_stcp  in  1  column latch strobe, asynchronous
ser_n_enable  in  1  column output enable, active low, asynchronous
pix_data  out  SPI_SIZE  assembled pixel word
pix_addr  out  $clog2(WORDS_PER_MATRIX)  pixel index within the frame
pix_valid  out  1  one-cycle strobe, pix_data/pix_addr valid
frame_done  out  1  one-cycle strobe, last pixel of the frame received
selected  out  1  tile currently selected
err_overrun  out  1  sticky: bits received after the frame completed
err_partial  out  1  sticky: deselected with 1..SPI_SIZE-1 bits pending
frame_count  out  16  frames completed (MATRIX_RX_STATS_EN only)
error_count  out  16  error events (MATRIX_RX_STATS_EN only)

Behaviour:
- Synchronisation: all six async inputs pass through 2-FF synchronisers. Rising edges are detected on the synchronised spi_clk, ser_clk and ser_stcp. Input-to-action latency is 3 clk cycles.
- Shift chain: on each ser_clk rise, chain <= {chain[CHAIN_LENGTH-2:0], ser_data}. On each ser_stcp rise, latch <= chain.
- Selection: selected = latch[TAP_INDEX] & ~ser_n_enable_sync. Registered; resets to 0.
- States:
  - IDLE: waiting for selection. On selected rising, clear the bit counter and go to RECV.
  - RECV: on each spi_clk rise, shift in spi_mosi per MSB_FIRST and increment bit_cnt.
    - When bit_cnt reaches SPI_SIZE: pulse pix_valid with pix_data and pix_addr = word_cnt, increment word_cnt, clear bit_cnt.
    - When word_cnt = WORDS_PER_MATRIX-1 on that write: also pulse frame_done in the same cycle, then go to DONE.
  - DONE: any spi_clk rise sets err_overrun; no pix_valid is produced.
- Deselect (selected falls) in RECV or DONE:
  - If bit_cnt != 0, set err_partial.
  - Go to IDLE, clear bit_cnt. word_cnt is kept, so a column may be split across multiple selections.
- New frame: a ser_stcp rise with latch[0]=1 (the chain's extra_bit marks column 0) clears word_cnt and bit_cnt, then enters IDLE or RECV according to selected. This takes priority over a simultaneous spi_clk rise; that bit is discarded.
- Simultaneous spi_clk rise and deselect: deselect wins and the bit is discarded.
- word_cnt saturates at WORDS_PER_MATRIX-1 and never wraps.
- Reset values:
  - outputs: pix_data=0, pix_addr=0, pix_valid=0, frame_done=0, selected=0, err_*=0, counters=0
  - internal: chain=0, latch=0, state IDLE
- Sticky errors clear only on rst_n.
- Reset mid-word discards all partial data.

Optional Feature:
Macro MATRIX_RX_STATS_EN.
- Defined: frame_count increments on each frame_done. error_count increments on each new err_overrun or err_partial event, including repeats while the flag is already set. Both saturate at 16'hFFFF.
- Undefined: no counters are synthesised; frame_count and error_count are driven constant 0.

Test Plan:
1. Reset with TAP_INDEX=0: shift ser_data=1 plus 15 zeros, strobe stcp, ser_n_enable=0 -> selected=1. Send 128 words 0x000000..0x00007F MSB first -> 128 pix_valid with pix_addr=pix_data[6:0]; frame_done coincides with addr 127.
2. MSB_FIRST=0: send bit pattern of 0xA5C3F0 LSB first -> pix_data=0xA5C3F0.
3. After frame_done, send 5 extra spi_clk pulses -> err_overrun=1, no pix_valid; error_count=5 with MATRIX_RX_STATS_EN.
4. Deassert ser_n_enable after 10 bits -> err_partial=1, bit_cnt cleared. Reselect and send 24 bits of 0x123456 -> pix_data=0x123456 at the next address.
5. TAP_INDEX=3 with select bit at chain position 0 -> selected=0 and 24 spi_clk produce no pix_valid. Shift 3 more, strobe -> selected=1.
6. New-frame stcp (latch[0]=1) mid-frame at word 40 -> next word is written at pix_addr=0. Assert rst_n low mid-word -> all outputs return to reset values.
